// File: rtl/demux4_buf_if.sv
// Handshake bundle for the registered 1-to-4 demultiplexer.
// The producer drives in_valid/d/s, the consumers drive r0..r3, and the
// demux returns in_ready, the four channel buffers and their valid flags.
interface demux4_buf_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic [1:0]       s;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;
    logic             v0;
    logic             v1;
    logic             v2;
    logic             v3;
    logic             r0;
    logic             r1;
    logic             r2;
    logic             r3;
    logic [3:0]       pend;

    // Producer/consumer side (testbench or surrounding datapath)
    modport master (
        output in_valid, d, s, r0, r1, r2, r3,
        input  in_ready, y0, y1, y2, y3, v0, v1, v2, v3, pend
    );

    // Demux side
    modport slave (
        input  in_valid, d, s, r0, r1, r2, r3,
        output in_ready, y0, y1, y2, y3, v0, v1, v2, v3, pend
    );
endinterface

// File: rtl/demux4_buf.sv
// Registered 1-to-4 demultiplexer. Each output channel owns a one-entry
// buffer (full flag + data word). The input is stalled only by the channel
// it currently targets, so a busy consumer never blocks the other three.
module demux4_buf #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    demux4_buf_if.slave bus
);

    logic [3:0]       full;
    logic [WIDTH-1:0] data_q [4];
    logic [3:0]       r_vec;
    logic [3:0]       drain;
    logic [3:0]       acc_vec;
    logic             ready;
    logic             accept;

    // Handshake decode: readiness follows only the selected channel, and a
    // channel that is draining this cycle can take a new word at the same edge.
    always_comb begin
        r_vec   = {bus.r3, bus.r2, bus.r1, bus.r0};
        ready   = ~full[bus.s] | r_vec[bus.s];
        accept  = bus.in_valid & ready;
        drain   = full & r_vec;
        acc_vec = 4'b0000;
        if (accept) begin
            acc_vec[bus.s] = 1'b1;
        end
    end

    // Per-channel buffer update; an accept wins over a drain so a channel
    // can sustain one word per cycle. Empty channels keep their stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc_vec[i]) begin
                    full[i]   <= 1'b1;
                    data_q[i] <= bus.d;
                end else if (drain[i]) begin
                    full[i]   <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready = ready;
    assign bus.y0       = data_q[0];
    assign bus.y1       = data_q[1];
    assign bus.y2       = data_q[2];
    assign bus.y3       = data_q[3];
    assign bus.v0       = full[0];
    assign bus.v1       = full[1];
    assign bus.v2       = full[2];
    assign bus.v3       = full[3];
    assign bus.pend     = full;

endmodule
